// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, behind a start/done handshake.
// One borrow flop replaces the ripple chain; an n-bit op takes n+2 cycles end to end.
module serial_subtractor #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] d,
  output logic         b_out,
  output logic         overflow
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);
  localparam logic [CW-1:0] PRE  = CW'(n - 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [n-1:0]    x_q, x_d;
  logic [n-1:0]    y_q, y_d;
  logic [n-1:0]    res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            b_q, b_d;
  logic            b_msb_q, b_msb_d;
  logic [n-1:0]    d_q, d_d;
  logic            b_out_q, b_out_d;
  logic            ovf_q, ovf_d;

  logic            xi, yi, di, b_nxt;
  logic [n-1:0]    res_sh;

  always_comb begin
    xi     = x_q[0];
    yi     = y_q[0];
    di     = xi ^ yi ^ b_q;
    b_nxt  = (~xi & yi) | (~(xi ^ yi) & b_q);
    res_sh = {di, res_q[n-1:1]};

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    b_msb_d = b_msb_q;
    d_d     = d_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          b_d     = b_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        x_d   = {1'b0, x_q[n-1:1]};
        y_d   = {1'b0, y_q[n-1:1]};
        b_d   = b_nxt;
        res_d = res_sh;
        cnt_d = cnt_q + 1'b1;
        // borrow leaving bit n-2 is the borrow into the MSB
        if (cnt_q == PRE) begin
          b_msb_d = b_nxt;
        end
        if (cnt_q == LAST) begin
          d_d     = res_sh;
          b_out_d = b_nxt;
          ovf_d   = b_msb_q ^ b_nxt;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      b_msb_q <= 1'b0;
      d_q     <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      b_msb_q <= b_msb_d;
      d_q     <= d_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign d        = d_q;
  assign b_out    = b_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed n=4 cases plus an n=8 random
// regression against an arithmetic reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       s4, b4, busy4, done4, bo4, ov4;
  logic [3:0] x4, y4, d4;
  logic       s8, b8, busy8, done8, bo8, ov8;
  logic [7:0] x8, y8, d8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.n(4)) u4 (
    .clk(clk), .reset(reset), .start(s4), .x(x4), .y(y4), .b_in(b4),
    .busy(busy4), .done(done4), .d(d4), .b_out(bo4), .overflow(ov4)
  );

  serial_subtractor #(.n(8)) u8 (
    .clk(clk), .reset(reset), .start(s8), .x(x8), .y(y8), .b_in(b8),
    .busy(busy8), .done(done8), .d(d8), .b_out(bo8), .overflow(ov8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void refm(input int w, input int xa, input int ya,
                               input int ba, output int ed, output int eb,
                               output int eo);
    int half, sx, sy, sd;
    half = 1 << (w - 1);
    ed = (xa - ya - ba) & ((1 << w) - 1);
    eb = (xa < ya + ba) ? 1 : 0;
    sx = (xa >= half) ? xa - 2 * half : xa;
    sy = (ya >= half) ? ya - 2 * half : ya;
    sd = sx - sy - ba;
    eo = (sd < -half || sd > half - 1) ? 1 : 0;
  endfunction

  task automatic drive(input int w, input bit st, input int xa,
                       input int ya, input int ba);
    if (w == 4) begin
      s4 = st; x4 = 4'(xa); y4 = 4'(ya); b4 = ba[0];
    end else begin
      s8 = st; x8 = 8'(xa); y8 = 8'(ya); b8 = ba[0];
    end
  endtask

  function automatic logic g_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction
  function automatic logic g_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction
  function automatic logic [7:0] g_d(input int w);
    return (w == 4) ? {4'b0, d4} : d8;
  endfunction
  function automatic logic g_bo(input int w);
    return (w == 4) ? bo4 : bo8;
  endfunction
  function automatic logic g_ov(input int w);
    return (w == 4) ? ov4 : ov8;
  endfunction

  // inj>0: pulse start with other operands at that many cycles after accept
  task automatic op(input int w, input int xa, input int ya, input int ba,
                    input int inj);
    int ed, eb, eo, lat, bcnt, extra;
    bit seen;
    refm(w, xa, ya, ba, ed, eb, eo);
    @(negedge clk);
    drive(w, 1'b1, xa, ya, ba);
    @(posedge clk); #1;
    drive(w, 1'b0, $urandom, $urandom, $urandom);
    lat = 0; bcnt = 0; seen = 0;
    while (lat < 4 * w) begin
      if (inj > 0 && lat == inj)
        drive(w, 1'b1, ~xa, ya + 3, ~ba);
      else if (inj > 0 && lat == inj + 1)
        drive(w, 1'b0, xa, ya, ba);
      if (g_busy(w)) bcnt++;
      if (g_done(w)) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", lat, w);
    chk("busy_cycles", bcnt, w + 1);
    chk("d", 32'(g_d(w)), ed);
    chk("b_out", 32'(g_bo(w)), eb);
    chk("overflow", 32'(g_ov(w)), eo);
    @(posedge clk); #1;
    drive(w, 1'b0, xa, ya, ba);
    chk("done_drop", 32'(g_done(w)), 32'd0);
    chk("busy_drop", 32'(g_busy(w)), 32'd0);
    if (inj > 0) begin
      extra = 0;
      for (int i = 0; i < w + 3; i++) begin
        @(posedge clk); #1;
        if (g_done(w) || g_busy(w)) extra++;
      end
      chk("ignored_start", extra, 0);
      chk("d_hold", 32'(g_d(w)), ed);
    end
  endtask

  initial begin
    int cyc, ndone, last, gap_bad, bound, rx, ry, rb, extra;
    int corners[4];
    corners[0] = 8'h80; corners[1] = 8'h7F;
    corners[2] = 8'h00; corners[3] = 8'hFF;
    reset = 1'b1;
    drive(4, 1'b0, 0, 0, 0);
    drive(8, 1'b0, 0, 0, 0);
    #22;
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_d", 32'(d4), 0);
    chk("rst_bo_ov", 32'({bo4, ov4}), 0);
    chk("rst8_all", 32'({busy8, done8, d8, bo8, ov8}), 0);
    @(negedge clk);
    reset = 1'b0;

    op(4, 5, 3, 0, 0);
    op(4, 0, 1, 0, 0);
    op(4, 7, 15, 0, 0);
    op(4, 8, 1, 0, 0);
    op(4, 8, 1, 1, 0);
    op(4, 12, 5, 0, 1);
    op(4, 3, 9, 1, 4);

    // start held high: one op every n+2 cycles
    @(negedge clk);
    drive(4, 1'b1, 6, 1, 0);
    ndone = 0; last = -1; gap_bad = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (done4) begin
        chk("held_d", 32'(d4), 5);
        if (last >= 0 && cyc - last != 6) gap_bad++;
        last = cyc;
        ndone++;
      end
    end
    chk("held_count", ndone, 6);
    chk("held_gap", gap_bad, 0);
    drive(4, 1'b0, 0, 0, 0);
    bound = 0;
    while (busy4 && bound < 20) begin
      @(posedge clk); #1;
      bound++;
    end
    chk("held_idle", 32'(busy4), 0);

    // reset in the 2nd SHIFT cycle
    op(4, 2, 9, 0, 0);
    @(negedge clk);
    drive(4, 1'b1, 9, 2, 0);
    @(posedge clk); #1;
    drive(4, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy4), 0);
    chk("mid_rst_done", 32'(done4), 0);
    chk("mid_rst_out", 32'({d4, bo4, ov4}), 0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) extra++;
    end
    chk("mid_rst_nodone", extra, 0);
    op(4, 9, 2, 0, 0);

    // n=8 corners then random regression
    op(8, 8'h80, 8'h01, 0, 0);
    op(8, 8'h7F, 8'hFF, 0, 0);
    op(8, 8'h00, 8'hFF, 1, 0);
    op(8, 8'hFF, 8'h80, 1, 0);
    for (int k = 0; k < 1000; k++) begin
      rx = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)]
                                      : int'($urandom & 8'hFF);
      ry = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)]
                                      : int'($urandom & 8'hFF);
      rb = int'($urandom & 1);
      op(8, rx, ry, rb, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
